// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - shared state encoding and select-width helper for stream_demux_n
package demux_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOCK = 2'd1,
    DROP = 2'd2
  } state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/stream_demux_slot.sv
// rtl/stream_demux_slot.sv - one-entry output register holding a beat and its last flag
module stream_demux_slot #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             last_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             last_o
);

  logic             valid_q, valid_d;
  logic [WIDTH:0]   beat_q, beat_d;

  // A load wins over a drain so a same-cycle refill keeps the slot full.
  always_comb begin
    valid_d = valid_q;
    beat_d  = beat_q;
    if (load_i) begin
      valid_d = 1'b1;
      beat_d  = {last_i, data_i};
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      beat_q  <= '0;
    end else begin
      valid_q <= valid_d;
      beat_q  <= beat_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = beat_q[WIDTH-1:0];
  assign last_o  = beat_q[WIDTH];

endmodule

// File: rtl/stream_demux_n.sv
// rtl/stream_demux_n.sv - 1-to-NCH packet-locked stream demux with per-channel output slots
module stream_demux_n
  import demux_pkg::*;
#(
  parameter int  WIDTH = 8,
  parameter int  NCH   = 4,
  localparam int SELW  = (clog2(NCH) < 1) ? 1 : clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     in_data,
  input  logic [SELW-1:0]      in_sel,
  input  logic                 in_last,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [NCH*WIDTH-1:0] out_data,
  output logic [NCH-1:0]       out_last,
  output logic [NCH-1:0]       out_valid,
  input  logic [NCH-1:0]       out_ready,
  output logic                 err_sel
);

  state_e          state_q;
  logic [SELW-1:0] cur_sel_q;
  logic            err_q;

  logic [SELW-1:0] dest;
  logic            dest_ok;
  logic            dest_free;
  logic            accept;
  logic [NCH-1:0]  dest_oh;
  logic [NCH-1:0]  load;

  assign dest    = (state_q == LOCK) ? cur_sel_q : in_sel;
  // Widen by one bit so NCH itself is representable when it is a power of two.
  assign dest_ok = ({1'b0, dest} < (SELW+1)'(NCH));

  always_comb begin
    dest_oh = '0;
    for (int k = 0; k < NCH; k++) begin
      dest_oh[k] = (dest == SELW'(k));
    end
  end

  assign dest_free = |(dest_oh & (~out_valid | out_ready));
  assign in_ready  = !rst && (state_q == DROP || !dest_ok || dest_free);
  assign accept    = in_valid && in_ready;
  assign load      = (accept && state_q != DROP && dest_ok) ? dest_oh : '0;
  assign err_sel   = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cur_sel_q <= '0;
      err_q     <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (accept) begin
        case (state_q)
          IDLE: begin
            if (!dest_ok) begin
              err_q <= 1'b1;
              if (!in_last) state_q <= DROP;
            end else if (!in_last) begin
              state_q   <= LOCK;
              cur_sel_q <= in_sel;
            end
          end
          LOCK:    if (in_last) state_q <= IDLE;
          DROP:    if (in_last) state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_slot
    stream_demux_slot #(.WIDTH(WIDTH)) u_slot (
      .clk     (clk),
      .rst     (rst),
      .load_i  (load[k]),
      .data_i  (in_data),
      .last_i  (in_last),
      .ready_i (out_ready[k]),
      .valid_o (out_valid[k]),
      .data_o  (out_data[k*WIDTH +: WIDTH]),
      .last_o  (out_last[k])
    );
  end

endmodule
